// File: rtl/divider_mode_ctrl.sv
// divider_mode_ctrl: push-button mode controller for the board clock divider.
// Four raw buttons are synchronized, debounced and edge-detected. Simultaneous
// presses resolve to the lowest button index. The winning request is latched
// and committed only on the wrap of a free-running 4-bit counter, so the LED
// never shows a runt pulse or a truncated phase. led and div_tick are
// registered outputs computed from next-state values.
module divider_mode_ctrl #(
  parameter int DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       swbtn_1,
  input  logic       swbtn_2,
  input  logic       swbtn_3,
  input  logic       swbtn_4,
  output logic       led,
  output logic [1:0] mode,
  output logic       pending,
  output logic       div_tick
);

  // Last debounce count value before a level change is accepted.
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  // Button vector, bit 0 = swbtn_1 (highest priority).
  logic [3:0] btn_raw;
  assign btn_raw = {swbtn_4, swbtn_3, swbtn_2, swbtn_1};

  // Synchronizer, debounce and edge-detect state.
  logic [3:0] sync_q1;
  logic [3:0] sync_q2;
  logic [3:0] db_level;
  logic [3:0] db_level_next;
  logic [3:0] db_level_d;
  logic [3:0] press;
  logic [7:0] db_cnt      [4];
  logic [7:0] db_cnt_next [4];

  // Arbitration result.
  logic       ev_valid;
  logic [1:0] ev_mode;

  // Divider and commit state.
  logic [3:0] cnt;
  logic [1:0] pend_mode;
  logic [3:0] cnt_next;
  logic [1:0] mode_next;
  logic [1:0] pend_mode_next;
  logic       pending_next;
  logic       wrap;
  logic       commit;
  logic       led_next;
  logic       div_tick_next;

  // Two-flop synchronizer for each raw button.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce next state: count consecutive differing samples, accept the new
  // level once the count has reached DB_LAST and the sample still differs.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_cnt_next[i]   = db_cnt[i];
      db_level_next[i] = db_level[i];
      if (sync_q2[i] == db_level[i]) begin
        db_cnt_next[i] = '0;
      end else if (db_cnt[i] == DB_LAST) begin
        db_level_next[i] = sync_q2[i];
        db_cnt_next[i]   = '0;
      end else begin
        db_cnt_next[i] = db_cnt[i] + 8'd1;
      end
    end
  end

  // Debounce counters and debounced levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_level <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      db_level <= db_level_next;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= db_cnt_next[i];
      end
    end
  end

  // Registered press pulse on each debounced 0->1 transition only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_level_d <= '0;
      press      <= '0;
    end else begin
      db_level_d <= db_level;
      press      <= db_level & ~db_level_d;
    end
  end

  // Fixed-priority arbiter: lowest button index wins.
  always_comb begin
    ev_valid = |press;
    ev_mode  = 2'd0;
    if (press[0]) begin
      ev_mode = 2'd0;
    end else if (press[1]) begin
      ev_mode = 2'd1;
    end else if (press[2]) begin
      ev_mode = 2'd2;
    end else if (press[3]) begin
      ev_mode = 2'd3;
    end
  end

  // Next-state for counter, request latch, committed mode and outputs.
  // A commit uses the pend_mode held before this edge; a new event on the
  // same edge re-arms pending with the newer request for the next wrap.
  always_comb begin
    cnt_next       = cnt + 4'd1;
    wrap           = (cnt == 4'hF);
    commit         = pending && wrap;
    mode_next      = mode;
    pend_mode_next = pend_mode;
    pending_next   = pending;
    if (commit) begin
      mode_next    = pend_mode;
      pending_next = 1'b0;
    end
    if (ev_valid) begin
      pend_mode_next = ev_mode;
      pending_next   = 1'b1;
    end
    led_next      = cnt_next[mode_next];
    div_tick_next = led_next && !led;
  end

  // Divider, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      mode      <= 2'd0;
      pend_mode <= 2'd0;
      pending   <= 1'b0;
      led       <= 1'b0;
      div_tick  <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      mode      <= mode_next;
      pend_mode <= pend_mode_next;
      pending   <= pending_next;
      led       <= led_next;
      div_tick  <= div_tick_next;
    end
  end

endmodule
